// File: rtl/mips_cpu_multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_multdiv_pkg
// Description : Shared types for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_multdiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_t;

    localparam int MD_OP_RESERVED_MIN = 6;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_multdiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_multdiv_signfix
// Description : Operand magnitude/sign extraction and final two's-complement
//               correction of product, quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_multdiv_signfix
    import mips_cpu_multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_sgn,
    output logic [WIDTH-1:0]   o_mag_a,
    output logic [WIDTH-1:0]   o_mag_b,
    output logic               o_neg_a,
    output logic               o_neg_b,
    input  logic [2*WIDTH-1:0] i_raw,
    input  logic               i_is_div,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    input  logic               i_div_zero,
    output logic [WIDTH-1:0]   o_fix_hi,
    output logic [WIDTH-1:0]   o_fix_lo
);

    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod;

    assign o_neg_a = i_sgn & i_a[WIDTH-1];
    assign o_neg_b = i_sgn & i_b[WIDTH-1];
    // -2^(WIDTH-1) maps to itself; read as unsigned it is the correct magnitude
    assign o_mag_a = o_neg_a ? -i_a : i_a;
    assign o_mag_b = o_neg_b ? -i_b : i_b;

    assign w_quot = i_raw[WIDTH-1:0];
    assign w_rem  = i_raw[2*WIDTH-1:WIDTH];

    always_comb begin
        o_fix_hi = '0;
        o_fix_lo = '0;
        w_prod   = i_neg_q ? -i_raw : i_raw;
        if (!i_is_div) begin
            o_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            o_fix_lo = w_prod[WIDTH-1:0];
        end else begin
            // Divide by zero leaves all-ones quotient regardless of signs
            o_fix_lo = i_div_zero ? '1 : (i_neg_q ? -w_quot : w_quot);
            o_fix_hi = i_neg_r ? -w_rem : w_rem;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_multdiv
// Description : Iterative shift-add multiplier / restoring divider with HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_multdiv
    import mips_cpu_multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0]       c_st_idle  = 2'(IDLE);
    localparam logic [1:0]       c_st_run   = 2'(RUN);
    localparam logic [1:0]       c_st_fin   = 2'(FIN);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_work;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_isdiv;
    logic               r_negq;
    logic               r_negr;
    logic               r_divz;
    logic               r_busy;
    logic               r_done;

    logic               w_sgn;
    logic               w_reserved;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH:0]   w_step;

    assign w_sgn      = (op == MD_MULT) || (op == MD_DIV);
    assign w_reserved = (op >= 3'(MD_OP_RESERVED_MIN));

    mips_cpu_multdiv_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .i_a        (a),
        .i_b        (b),
        .i_sgn      (w_sgn),
        .o_mag_a    (w_mag_a),
        .o_mag_b    (w_mag_b),
        .o_neg_a    (w_neg_a),
        .o_neg_b    (w_neg_b),
        .i_raw      (r_work[2*WIDTH-1:0]),
        .i_is_div   (r_isdiv),
        .i_neg_q    (r_negq),
        .i_neg_r    (r_negr),
        .i_div_zero (r_divz),
        .o_fix_hi   (w_fix_hi),
        .o_fix_lo   (w_fix_lo)
    );

    // Multiply: {acc, multiplier} shifts right; divide: {rem, dividend/quot} shifts left
    always_comb begin
        w_madd = r_work[2*WIDTH:WIDTH] + (r_work[0] ? {1'b0, r_opnd} : '0);
        w_diff = {1'b0, r_work[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opnd};
        if (!r_isdiv) begin
            w_step = {1'b0, w_madd, r_work[WIDTH-1:1]};
        end else if (!w_diff[WIDTH+1]) begin
            w_step = {w_diff[WIDTH:0], r_work[WIDTH-2:0], 1'b1};
        end else begin
            w_step = {r_work[2*WIDTH-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_work  <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_isdiv <= 1'b0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_divz  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start && !w_reserved) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                r_work  <= {{(WIDTH+1){1'b0}}, w_mag_b};
                                r_opnd  <= w_mag_a;
                                r_isdiv <= 1'b0;
                                r_negq  <= w_neg_a ^ w_neg_b;
                                r_negr  <= w_neg_a;
                                r_divz  <= 1'b0;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= c_st_run;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_work  <= {{(WIDTH+1){1'b0}}, w_mag_a};
                                r_opnd  <= w_mag_b;
                                r_isdiv <= 1'b1;
                                r_negq  <= w_neg_a ^ w_neg_b;
                                r_negr  <= w_neg_a;
                                r_divz  <= (b == '0);
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= c_st_run;
                            end
                            MD_MTHI: r_hi <= a;
                            MD_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                c_st_run: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_fin;
                    end
                end
                c_st_fin: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_multdiv
// Description : Directed self-checking bench for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_multdiv;
    import mips_cpu_multdiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        int nb;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_on"}, 64'(busy), 64'd1);
        n  = 0;
        nb = 1;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (busy === 1'b1) nb++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        logic [W-1:0] x, y, ehi, elo;
        logic [2:0]   o;
        logic [63:0]  p;
        int           sx, sy, n;
        bit           seen;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        @(negedge clk); reset = 1'b0;

        do_op("mult_neg",  MD_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_zero", MD_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        do_op("div_zero",  MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        do_op("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // MTHI / MTLO take effect at the accepting edge without busy or done
        @(negedge clk); start = 1'b1; op = MD_MTHI; a = 32'h1234;
        @(posedge clk); #1; start = 1'b0;
        chk("mthi_hi",   64'(hi),   64'h1234);
        chk("mthi_lo",   64'(lo),   64'h80000000);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        @(negedge clk); start = 1'b1; op = MD_MTLO; a = 32'hABCD;
        @(posedge clk); #1; start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'hABCD);
        chk("mtlo_hi", 64'(hi), 64'h1234);

        // Reserved op ignored
        @(negedge clk); start = 1'b1; op = 3'd6; a = 32'h5555; b = 32'd1;
        @(posedge clk); #1; start = 1'b0;
        chk("rsvd_hi",   64'(hi),   64'h1234);
        chk("rsvd_lo",   64'(lo),   64'hABCD);
        chk("rsvd_busy", 64'(busy), 64'd0);

        // Start while busy is dropped; reset mid-operation aborts everything
        @(negedge clk); start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MD_MTLO; a = 32'hDEAD;
        @(posedge clk); #1; start = 1'b0;
        chk("busy_ign_lo",   64'(lo),   64'hABCD);
        chk("busy_ign_hi",   64'(hi),   64'h1234);
        chk("busy_ign_busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi",   64'(hi),   64'd0);
        chk("abort_lo",   64'(lo),   64'd0);
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_idle",    64'(busy), 64'd0);

        // Back-to-back: start held through the done cycle
        @(negedge clk); start = 1'b1; op = MD_MULTU; a = 32'd6; b = 32'd7;
        @(negedge clk); op = MD_DIVU; a = 32'd100; b = 32'd7;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_done", 64'(done), 64'd1);
        chk("b2b_first_lo",   64'(lo),   64'd42);
        chk("b2b_first_hi",   64'(hi),   64'd0);
        @(posedge clk); #1; start = 1'b0;
        chk("b2b_accept_busy", 64'(busy), 64'd1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_lat", 64'(n),  64'd33);
        chk("b2b_second_lo",  64'(lo), 64'd14);
        chk("b2b_second_hi",  64'(hi), 64'd2);

        // Randomised operands against an arithmetic reference
        for (int k = 0; k < 8; k++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom >> $urandom_range(0, 28);
            if (y == '0) y = 32'd1;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
            sx = int'(x);
            sy = int'(y);
            case (o)
                3'd0: p = longint'($signed(x)) * longint'($signed(y));
                3'd1: p = {32'd0, x} * {32'd0, y};
                3'd2: p = {32'(sx % sy), 32'(sx / sy)};
                default: p = {x % y, x / y};
            endcase
            ehi = p[63:32];
            elo = p[31:0];
            do_op($sformatf("rand%0d_op%0d", k, o), o, x, y, ehi, elo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
